// File: rtl/mem_read_streamer_pkg.sv
// Shared definitions for the read streamer: FSM state encoding, buffer depth and default widths.
package mem_read_pkg;

    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int BUF_DEPTH      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rd_buf2.sv
// Two-entry synchronous FIFO; o_data always presents the head entry.
module rd_buf2
    import mem_read_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_occ
);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            unique case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_data = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/mem_read_streamer.sv
// Burst reader: issues base+i reads to a 1-cycle-latency memory and streams the words out valid/ready.
// Define READ_LAST_EN to add the last_o end-of-burst marker.
module mem_read_streamer
    import mem_read_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o,
`ifdef READ_LAST_EN
    output logic                  last_o,
`endif
    output logic [1:0]            dbg_state_o
);

    // Stream handshake: a beat transfers in any cycle where valid_o && ready_i;
    // while valid_o is high and ready_i low, data_o and valid_o hold their values.

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_accepted;
    logic                  r_inflight;

    logic [1:0]            w_occ;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_pop;
    logic                  w_room;
    logic                  w_mem_en;
    logic                  w_last_issue;
    logic                  w_last_accept;
    logic                  w_start;

    rd_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_inflight),
        .i_data (mem_rdata_i),
        .i_pop  (w_pop),
        .o_data (w_head),
        .o_occ  (w_occ)
    );

    assign valid_o = (w_occ != 2'd0);
    assign w_pop   = valid_o && ready_i;
    assign w_start = (r_state == IDLE) && start_i;

    // Words held plus the one returning this cycle, minus the one leaving, must leave a free slot.
    assign w_room        = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
    assign w_mem_en      = (r_state == RUN) && (r_issued < r_len) && w_room;
    assign w_last_issue  = w_mem_en && (r_issued == r_len - LEN_WIDTH'(1));
    assign w_last_accept = w_pop && (r_accepted == r_len - LEN_WIDTH'(1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next_state = (len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last_issue) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last_accept) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_mem_en;
            if (w_start) begin
                r_base     <= base_addr_i;
                r_len      <= len_i;
                r_issued   <= '0;
                r_accepted <= '0;
            end else begin
                if (w_mem_en) begin
                    r_issued <= r_issued + LEN_WIDTH'(1);
                end
                if (w_pop) begin
                    r_accepted <= r_accepted + LEN_WIDTH'(1);
                end
            end
        end
    end

    // Address wraps naturally at 2^ADDR_WIDTH.
    assign mem_en_o    = w_mem_en;
    assign mem_addr_o  = r_base + r_issued[ADDR_WIDTH-1:0];
    assign data_o      = w_head;
    assign busy_o      = (r_state != IDLE);
    assign done_o      = (r_state == DONE);
    assign dbg_state_o = r_state;

`ifdef READ_LAST_EN
    assign last_o = valid_o && (r_accepted == r_len - LEN_WIDTH'(1));
`endif

endmodule

// File: doc/mem_read_streamer.md
Name: mem_read_streamer

Overview:
- Read-side counterpart of the write-address counter: fetches a burst of words from the shared single-port buffer memory and streams them out with a valid/ready handshake.
- On start, generates sequential read addresses (base + i) and absorbs the memory's 1-cycle read latency in a 2-entry buffer.
- Signals done when the last word has been accepted downstream.
- Sits between the buffer memory and the downstream consumer (e.g. output DMA / checker).

Parameters:
ADDR_WIDTH, 7, memory address width (128 entries)
DATA_WIDTH, 32, memory word width
LEN_WIDTH, ADDR_WIDTH+1, burst length width (allows a full 2^ADDR_WIDTH burst)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  begin a burst; sampled only in IDLE
base_addr_i  input  ADDR_WIDTH  first read address, latched on start
len_i  input  LEN_WIDTH  number of words, latched on start; 0 allowed
mem_en_o  output  1  memory read enable
mem_addr_o  output  ADDR_WIDTH  memory read address
mem_rdata_i  input  DATA_WIDTH  read data, valid the cycle after mem_en_o
data_o  output  DATA_WIDTH  stream data (head of buffer)
valid_o  output  1  stream data valid
ready_i  input  1  downstream accepts data_o when valid_o && ready_i
busy_o  output  1  high in any state except IDLE
done_o  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset values: FSM in IDLE; mem_en_o=0, mem_addr_o=0, valid_o=0, data_o=0, busy_o=0, done_o=0. Buffer, issue counter, accept counter and in-flight flag cleared.
- FSM states:
  - IDLE -> RUN on start_i with len_i>0.
  - IDLE -> DONE on start_i with len_i==0. No memory access occurs.
  - RUN -> DRAIN in the cycle the final read is issued.
  - DRAIN -> DONE when the final beat is accepted.
  - DONE -> IDLE unconditionally after 1 cycle; done_o=1 only in DONE.
- start_i outside IDLE is ignored. base and len are not re-latched.
- Issue rule, in RUN:
  - mem_en_o = (issued < len) && (occ + inflight - pop) < 2.
  - occ = buffer occupancy; inflight = read issued last cycle; pop = valid_o && ready_i.
  - mem_addr_o = base + issued, modulo 2^ADDR_WIDTH (wrap allowed, no error).
  - mem_en_o is combinational from registered state only. It never depends on mem_rdata_i.
- Capture: the word read with mem_en_o in cycle N is written into the buffer at the end of cycle N+1. valid_o rises in cycle N+2.
- Latency: start_i sampled at edge E0 -> mem_en_o high in cycle 1 -> valid_o high in cycle 3.
- Throughput: 1 word/cycle sustained while ready_i=1.
- Handshake: once valid_o=1, data_o and valid_o are held stable until accepted. Words are delivered strictly in address order, none dropped or duplicated.
- Buffer is never overrun: the issue rule guarantees occ<=2 including the in-flight word. Simultaneous push and pop at occ=2 is impossible by construction; at occ=1 it keeps occ=1.
- Reset mid-burst: immediate return to IDLE, buffer flushed, no done_o. Any pending memory read is discarded.
- Counters are LEN_WIDTH bits and never wrap within a burst.

Optional Feature:
- Macro: READ_LAST_EN.
- Defined: adds output last_o (1 bit). last_o=1 together with valid_o on the final word of the burst, else 0. Reset value 0.
- Undefined: port absent. The accept counter is still used for DRAIN->DONE.

Decomposition:
- Package mem_read_pkg holds:
  - state encoding localparams IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3
  - BUF_DEPTH=2
  - default widths
- Sub-module rd_buf2: 2-entry synchronous FIFO with push/pop/occ, data_o = head. Reset asynchronous active-low.
- FSM, counters and issue logic stay in the top module.

Test Plan:
- Basic burst: base=5, len=4, ready_i=1 -> mem_addr_o 5,6,7,8 in cycles 1-4. data_o = mem[5..8] in cycles 3-6. done_o pulse in cycle 7, busy_o low after.
- Backpressure: len=6, ready_i toggling 1,0,0,1,... -> data_o stable while stalled. mem_en_o never leaves occ+inflight>2. All 6 words arrive in order.
- Wrap: base=126, len=4 -> addresses 126,127,0,1; data correct, no error.
- len=0: start_i -> no mem_en_o, done_o one cycle later, valid_o stays 0.
- Reset mid-burst: len=10, assert rst_n=0 after 3 accepted words -> all outputs at reset values. A new start with base=0, len=2 then delivers mem[0], mem[1] only.
- READ_LAST_EN build: len=3 -> last_o=1 only with the third word. Start pulses during RUN are ignored (no re-latch).
